// File: rtl/power2round_skdecode_pkg.sv
// Shared constants for the t0 sk-decode path (ML-DSA parameters, stream geometry).
package power2round_skdecode_pkg;
  localparam int REG_SIZE  = 23;
  localparam int MLDSA_Q   = 8380417;
  localparam int MLDSA_D   = 13;
  localparam int MLDSA_N   = 256;
  localparam int IN_W      = 32;
  localparam int BUF_W     = 64;
  localparam int NUM_WORDS = MLDSA_N * MLDSA_D / IN_W;  // 104
  localparam int OFFSET    = 1 << (MLDSA_D - 1);        // 4096
  localparam int CNT_W     = 7;                         // holds 0..64 and 0..104
  localparam int COEF_CW   = $clog2(MLDSA_N);           // wraps on the 256th pop
endpackage

// File: rtl/power2round_skdecode_if.sv
// Handshake bundle between the sk word reader, the decoder and the coefficient sink.
interface power2round_skdecode_if;
  import power2round_skdecode_pkg::*;

  logic                start;
  logic [IN_W-1:0]     in_data;
  logic                in_valid;
  logic                in_ready;
  logic [REG_SIZE-1:0] coef_o;
  logic                coef_valid;
  logic                coef_ready;
  logic                busy;
  logic                done;

  modport master (
    output start, in_data, in_valid, coef_ready,
    input  in_ready, coef_o, coef_valid, busy, done
  );

  modport slave (
    input  start, in_data, in_valid, coef_ready,
    output in_ready, coef_o, coef_valid, busy, done
  );
endinterface

// File: rtl/power2round_skdecode_coef.sv
// Maps one packed 13-bit t0 field back to its coefficient in [0,Q): r0 = 4096 - field mod Q.
module power2round_skdecode_coef
  import power2round_skdecode_pkg::*;
(
  input  logic [MLDSA_D-1:0]  field,
  output logic [REG_SIZE-1:0] coef
);
  logic signed [REG_SIZE:0] t;
  logic signed [REG_SIZE:0] r;
  logic                     r_msb_unused;

  // t spans -4095..4096, so a single conditional add of Q lands in range.
  always_comb begin
    t = $signed((REG_SIZE+1)'(OFFSET)) - $signed({{(REG_SIZE+1-MLDSA_D){1'b0}}, field});
    r = t[REG_SIZE] ? t + $signed((REG_SIZE+1)'(MLDSA_Q)) : t;
  end

  assign {r_msb_unused, coef} = r;
endmodule

// File: rtl/power2round_skdecode.sv
// t0 sk-decode: unpacks 104 x 32-bit words into 256 x 13-bit fields and emits mod-Q coefficients.
module power2round_skdecode
  import power2round_skdecode_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  power2round_skdecode_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [BUF_W-1:0]     bit_buf, buf_nxt;
  logic [CNT_W-1:0]     cnt, words_in, wr_pos;
  logic [COEF_CW-1:0]   coef_cnt;
  logic [REG_SIZE-1:0]  coef_map;
  logic                 push, pop;

  // Ready/valid depend on registers only, so the source sees no combinational loop.
  assign bus.in_ready   = (state == RUN) && (cnt <= CNT_W'(IN_W)) && (words_in < CNT_W'(NUM_WORDS));
  assign bus.coef_valid = (state == RUN) && (cnt >= CNT_W'(MLDSA_D));
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.coef_valid & bus.coef_ready;

  power2round_skdecode_coef u_coef (
    .field (bit_buf[MLDSA_D-1:0]),
    .coef  (coef_map)
  );

  // Outputs read as zero whenever nothing is offered (including reset).
  assign bus.coef_o = bus.coef_valid ? coef_map : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: the 256th coefficient handshake ends the polynomial.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (pop && (coef_cnt == COEF_CW'(MLDSA_N - 1))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs; busy covers the DONE cycle and drops right after it.
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // Buffer update: pop shifts first, then the new word lands just above the surviving bits.
  always_comb begin
    wr_pos  = cnt - (pop ? CNT_W'(MLDSA_D) : '0);
    buf_nxt = pop ? (bit_buf >> MLDSA_D) : bit_buf;
    if (push) buf_nxt = buf_nxt | ({{(BUF_W-IN_W){1'b0}}, bus.in_data} << wr_pos);
  end

  // Buffer and counters; cleared whenever not running so each start begins empty.
  always_ff @(posedge clk) begin
    if (rst || (state != RUN)) begin
      bit_buf  <= '0;
      cnt      <= '0;
      words_in <= '0;
      coef_cnt <= '0;
    end else begin
      bit_buf  <= buf_nxt;
      cnt      <= cnt + (push ? CNT_W'(IN_W) : '0) - (pop ? CNT_W'(MLDSA_D) : '0);
      words_in <= words_in + CNT_W'(push);
      coef_cnt <= coef_cnt + COEF_CW'(pop);
    end
  end
endmodule
